// File: rtl/adder_error_monitor.sv
// adder_error_monitor: streaming error-metric checker for N-bit approximate adders.
// Ports: clk, rst_n (async, active low); start/num_samples begin a run;
//   in_valid/in_ready handshake for in_a, in_b, in_s (operands + sum under test);
//   busy/done run status; sample_cnt, err_cnt, ed_sum, ed_max statistics.
// Optional macro ERR_MON_BIAS_EN adds bias_sum, the signed sum of (S - exact).
module adder_error_monitor #(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N-1:0]     ed_max
`ifdef ERR_MON_BIAS_EN
  ,
  output logic signed [ACC_W:0] bias_sum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             hs;
  logic [N-1:0]     exact, ed_d, ed_q;
  logic             v1_q, nz_q, neg_q;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W:0]   sum_x;
  logic [N-1:0]     max_q, max_d;

  // start wins over a coincident handshake: that sample is dropped
  assign hs    = in_valid && in_ready && !start;
  assign exact = in_a + in_b;
  assign ed_d  = (in_s > exact) ? in_s - exact : exact - in_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // DRAIN holds one cycle: with the handshake cycle that covers both
  // pipeline stages, so done rises together with the final stats
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (start) begin
      rem_d   = num_samples;
      state_d = (num_samples == '0) ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (hs) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
          end
        end
        S_DRAIN: state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      ed_q  <= '0;
      nz_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      v1_q <= hs;
      if (hs) begin
        ed_q  <= ed_d;
        nz_q  <= (ed_d != '0);
        neg_q <= (in_s < exact);
      end
    end
  end

  always_comb begin
    sum_x  = {1'b0, sum_q} + {{(ACC_W+1-N){1'b0}}, ed_q};
    scnt_d = scnt_q;
    ecnt_d = ecnt_q;
    sum_d  = sum_q;
    max_d  = max_q;
    if (start) begin
      scnt_d = '0;
      ecnt_d = '0;
      sum_d  = '0;
      max_d  = '0;
    end else if (v1_q) begin
      if (scnt_q != '1) scnt_d = scnt_q + CNT_W'(1);
      if (nz_q && ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
      sum_d = sum_x[ACC_W] ? '1 : sum_x[ACC_W-1:0];
      if (ed_q > max_q) max_d = ed_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      ecnt_q <= '0;
      sum_q  <= '0;
      max_q  <= '0;
    end else begin
      scnt_q <= scnt_d;
      ecnt_q <= ecnt_d;
      sum_q  <= sum_d;
      max_q  <= max_d;
    end
  end

  assign sample_cnt = scnt_q;
  assign err_cnt    = ecnt_q;
  assign ed_sum     = sum_q;
  assign ed_max     = max_q;

`ifdef ERR_MON_BIAS_EN
  logic signed [ACC_W:0]   bias_q, bias_d;
  logic signed [ACC_W+1:0] ed_x, bias_x;

  // one guard bit: sign disagreement between the top two bits is overflow
  always_comb begin
    ed_x   = $signed({{(ACC_W+2-N){1'b0}}, ed_q});
    bias_x = $signed({bias_q[ACC_W], bias_q}) + (neg_q ? -ed_x : ed_x);
    bias_d = bias_q;
    if (start) begin
      bias_d = '0;
    end else if (v1_q) begin
      if (bias_x[ACC_W+1] != bias_x[ACC_W])
        bias_d = bias_x[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}}
                                 : {1'b0, {ACC_W{1'b1}}};
      else
        bias_d = bias_x[ACC_W:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q <= '0;
    else        bias_q <= bias_d;
  end

  assign bias_sum = bias_q;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor: randomized bench for adder_error_monitor
// against an arithmetic reference model of the error statistics.
module tb_adder_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] num_samples = '0;
  logic [15:0] in_a = '0, in_b = '0, in_s = '0;
  logic        in_ready, busy, done;
  logic [31:0] sample_cnt, err_cnt;
  logic [47:0] ed_sum;
  logic [15:0] ed_max;
  logic        s_ready, s_busy, s_done;
  logic [31:0] s_scnt, s_ecnt;
  logic [15:0] s_sum, s_max;
`ifdef ERR_MON_BIAS_EN
  logic signed [48:0] bias_sum;
  logic signed [16:0] s_bias;
`endif

  int          chk = 0;
  int          pass = 0;
  int unsigned cyc = 0;
  longint      m_cnt, m_err, m_sum, m_max, m_bias;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adder_error_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_s(in_s), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .ed_sum(ed_sum), .ed_max(ed_max)
`ifdef ERR_MON_BIAS_EN
    , .bias_sum(bias_sum)
`endif
  );

  adder_error_monitor #(.N(16), .CNT_W(32), .ACC_W(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(s_ready), .in_a(in_a), .in_b(in_b),
    .in_s(in_s), .busy(s_busy), .done(s_done),
    .sample_cnt(s_scnt), .err_cnt(s_ecnt),
    .ed_sum(s_sum), .ed_max(s_max)
`ifdef ERR_MON_BIAS_EN
    , .bias_sum(s_bias)
`endif
  );

  function automatic void m_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_bias = 0;
  endfunction

  function automatic void m_push(input logic [15:0] a, b, s);
    int ex, d, ad;
    ex = (int'(a) + int'(b)) % 65536;
    d  = int'(s) - ex;
    ad = (d < 0) ? -d : d;
    m_cnt++;
    if (d != 0) m_err++;
    m_sum += ad;
    if (ad > m_max) m_max = ad;
    m_bias += d;
  endfunction

  function automatic logic [127:0] m_vec();
    return {32'(m_cnt), 32'(m_err), 48'(m_sum), 16'(m_max)};
  endfunction

  task automatic do_start(input int unsigned n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
    m_clear();
  endtask

  task automatic send(input logic [15:0] a, b, s);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_s = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      @(negedge clk);
    end
    if (!ok) begin
      chk++;
      $display("FAIL send_timeout in_ready stuck at %b", in_ready);
    end else begin
      m_push(a, b, s);
    end
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk++;
    if (done !== 1'b1) $display("FAIL %s_done got %b exp 1", tag, done);
    else pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if ({in_ready, busy, done, sample_cnt, err_cnt, ed_sum, ed_max} !== '0)
      $display("FAIL reset_state got %b%b%b %h %h %h %h exp all 0",
               in_ready, busy, done, sample_cnt, err_cnt, ed_sum, ed_max);
    else pass++;
  endtask

  task automatic test_exact();
    int unsigned t0;
    logic [15:0] a, b;
    do_start(1000);
    chk++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL exact_run got rdy=%b busy=%b done=%b exp 1 1 0",
               in_ready, busy, done);
    else pass++;
    t0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      send(a, b, 16'(a + b));
    end
    in_valid = 1'b0;
    chk++;
    if (int'(cyc - t0) !== 1000)
      $display("FAIL exact_throughput got %0d cycles exp 1000", cyc - t0);
    else pass++;
    chk++;
    if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL exact_drain got done=%b busy=%b rdy=%b exp 0 1 0",
               done, busy, in_ready);
    else pass++;
    @(negedge clk);
    chk++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL exact_done_latency got done=%b busy=%b exp 1 0",
               done, busy);
    else pass++;
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== {32'd1000, 32'd0, 48'd0, 16'd0})
      $display("FAIL exact_stats got %0d %0d %0d %0d exp 1000 0 0 0",
               sample_cnt, err_cnt, ed_sum, ed_max);
    else pass++;
  endtask

  task automatic test_random();
    logic [15:0] a, b, ex, s;
    int unsigned r;
    do_start(300);
    for (int i = 0; i < 300; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ex = 16'(a + b);
      r  = $urandom_range(0, 3);
      if (r == 0)      s = ex;
      else if (r == 1) s = 16'($urandom);
      else             s = ex ^ 16'($urandom_range(0, 255));
      send(a, b, s);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    wait_done("random");
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== m_vec())
      $display("FAIL random_stats got %h exp %h",
               {sample_cnt, err_cnt, ed_sum, ed_max}, m_vec());
    else pass++;
`ifdef ERR_MON_BIAS_EN
    chk++;
    if (bias_sum !== 49'(m_bias))
      $display("FAIL random_bias got %0d exp %0d", bias_sum, m_bias);
    else pass++;
`endif
  endtask

  task automatic test_wrap();
    do_start(2);
    send(16'hFFFF, 16'h0001, 16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    chk++;
    if (sample_cnt !== 32'd1 || err_cnt !== 32'd0)
      $display("FAIL wrap_exact got cnt=%0d err=%0d exp 1 0",
               sample_cnt, err_cnt);
    else pass++;
    send(16'h0000, 16'h0000, 16'hFFFF);
    in_valid = 1'b0;
    wait_done("wrap");
    chk++;
    if ({err_cnt, ed_sum, ed_max} !== {32'd1, 48'd65535, 16'hFFFF})
      $display("FAIL wrap_max got err=%0d sum=%0d max=%h exp 1 65535 ffff",
               err_cnt, ed_sum, ed_max);
    else pass++;
  endtask

  task automatic test_three();
    do_start(3);
    send(16'd10, 16'd0, 16'd10);
    send(16'd10, 16'd0, 16'd15);
    send(16'd10, 16'd0, 16'd22);
    in_valid = 1'b0;
    wait_done("three_pos");
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== {32'd3, 32'd2, 48'd17, 16'd12})
      $display("FAIL three_stats got %0d %0d %0d %0d exp 3 2 17 12",
               sample_cnt, err_cnt, ed_sum, ed_max);
    else pass++;
`ifdef ERR_MON_BIAS_EN
    chk++;
    if (bias_sum !== 49'sd17)
      $display("FAIL three_bias_pos got %0d exp 17", bias_sum);
    else pass++;
`endif
    do_start(3);
    send(16'd10, 16'd0, 16'd10);
    send(16'd10, 16'd0, 16'd5);
    send(16'd20, 16'd0, 16'd8);
    in_valid = 1'b0;
    wait_done("three_neg");
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== {32'd3, 32'd2, 48'd17, 16'd12})
      $display("FAIL three_neg_stats got %0d %0d %0d %0d exp 3 2 17 12",
               sample_cnt, err_cnt, ed_sum, ed_max);
    else pass++;
`ifdef ERR_MON_BIAS_EN
    chk++;
    if (bias_sum !== -49'sd17)
      $display("FAIL three_bias_neg got %0d exp -17", bias_sum);
    else pass++;
`endif
  endtask

  task automatic test_throttle();
    int hs;
    bit seen;
    hs = 0;
    seen = 1'b0;
    do_start(4);
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_s = 16'($urandom);
      if (in_valid && in_ready) begin
        hs++;
        m_push(in_a, in_b, in_s);
      end
      @(negedge clk);
      if (hs == 4 && !seen) begin
        seen = 1'b1;
        chk++;
        if (in_ready !== 1'b0)
          $display("FAIL throttle_ready_drop got %b exp 0", in_ready);
        else pass++;
      end
    end
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk++;
    if (hs !== 4 || done !== 1'b1)
      $display("FAIL throttle_hs got hs=%0d done=%b exp 4 1", hs, done);
    else pass++;
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== m_vec() || sample_cnt !== 32'd4)
      $display("FAIL throttle_stats got %h exp %h",
               {sample_cnt, err_cnt, ed_sum, ed_max}, m_vec());
    else pass++;
  endtask

  task automatic test_start_mid();
    do_start(5);
    send(16'd1, 16'd1, 16'd9);
    send(16'd2, 16'd2, 16'd0);
    start = 1'b1;
    num_samples = 32'd2;
    in_a = 16'd3; in_b = 16'd3; in_s = 16'd100;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    m_clear();
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== '0 || in_ready !== 1'b1)
      $display("FAIL restart_clear got %h rdy=%b exp 0 1",
               {sample_cnt, err_cnt, ed_sum, ed_max}, in_ready);
    else pass++;
    @(negedge clk);
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== '0)
      $display("FAIL restart_drop got %h exp 0",
               {sample_cnt, err_cnt, ed_sum, ed_max});
    else pass++;
    send(16'd7, 16'd8, 16'd16);
    send(16'd100, 16'd1, 16'd101);
    in_valid = 1'b0;
    wait_done("restart");
    chk++;
    if ({sample_cnt, err_cnt, ed_sum, ed_max} !== m_vec() || sample_cnt !== 32'd2)
      $display("FAIL restart_stats got %h exp %h",
               {sample_cnt, err_cnt, ed_sum, ed_max}, m_vec());
    else pass++;
    start = 1'b1;
    num_samples = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL zero_samples got done=%b busy=%b rdy=%b exp 1 0 0",
               done, busy, in_ready);
    else pass++;
  endtask

  task automatic test_reset_mid();
    do_start(10);
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 16'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if ({in_ready, busy, done, sample_cnt, err_cnt, ed_sum, ed_max} !== '0)
      $display("FAIL reset_mid got %b%b%b %h %h %h %h exp all 0",
               in_ready, busy, done, sample_cnt, err_cnt, ed_sum, ed_max);
    else pass++;
    #7 rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sample_cnt !== '0)
      $display("FAIL reset_idle got rdy=%b busy=%b done=%b cnt=%0d exp 0 0 0 0",
               in_ready, busy, done, sample_cnt);
    else pass++;
    m_clear();
  endtask

  task automatic test_saturation();
    do_start(2);
    send(16'd0, 16'd0, 16'hFFFF);
    send(16'd0, 16'd0, 16'hFFFF);
    in_valid = 1'b0;
    wait_done("sat");
    chk++;
    if (s_sum !== 16'hFFFF || s_max !== 16'hFFFF)
      $display("FAIL sat_ed_sum got sum=%h max=%h exp ffff ffff", s_sum, s_max);
    else pass++;
    chk++;
    if (ed_sum !== 48'(m_sum) || s_scnt !== 32'd2)
      $display("FAIL sat_wide got sum=%0d cnt=%0d exp %0d 2",
               ed_sum, s_scnt, m_sum);
    else pass++;
  endtask

  initial begin
    m_clear();
    test_reset();
    test_exact();
    test_random();
    test_wrap();
    test_three();
    test_throttle();
    test_start_mid();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
